// File: rtl/enigma_pkg.sv
// Shared letter type, letter range limits and scheduler FSM states.
package enigma_pkg;

  typedef logic [4:0] letter_t;

  localparam letter_t LETTER_NONE = 5'd0;
  localparam letter_t LETTER_MIN  = 5'd1;
  localparam letter_t LETTER_MAX  = 5'd26;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RESP,
    ST_ARM,
    ST_SHOW
  } state_t;

  function automatic logic letter_ok(input letter_t l);
    return (l >= LETTER_MIN) && (l <= LETTER_MAX);
  endfunction

endpackage

// File: rtl/enigma_key_fifo.sv
// Synchronous key FIFO: head is visible combinationally, pop takes effect on the clock.
// A push into a full FIFO is accepted only when a pop lands in the same cycle.
module enigma_key_fifo
  import enigma_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_vld,
  input  letter_t push_dat,
  input  logic    pop_rdy,
  output letter_t head_dat,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  letter_t       mem_q [DEPTH];
  letter_t       mem_d [DEPTH];
  logic          do_push, do_pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign head_dat = mem_q[rd_ptr_q];
  assign do_pop   = pop_rdy & ~empty;
  assign do_push  = push_vld & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: LETTER_NONE};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/enigma_lamp_scheduler.sv
// Queues keypresses, runs each through the cipher core and holds the lamp pair for HOLD_FRAMES frames.
// Optional `ENIGMA_LAMP_BLINK_EN blinks the ciphertext lamp on fc_in[3] while showing.
module enigma_lamp_scheduler
  import enigma_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int HOLD_FRAMES  = 30,
  parameter int RESP_TIMEOUT = 1024
) (
  input  logic       clk_pixel,
  input  logic       rst_n_in,
  input  logic       key_valid_in,
  input  logic [4:0] key_letter_in,
  input  logic       nf_in,
  input  logic [5:0] fc_in,
  output logic       enc_valid_out,
  output logic [4:0] enc_letter_out,
  input  logic       enc_ready_in,
  input  logic       enc_resp_valid_in,
  input  logic [4:0] enc_resp_letter_in,
  output logic [4:0] orig_letter_out,
  output logic [4:0] code_letter_out,
  output logic       busy_out,
  output logic       overflow_out,
  output logic       timeout_out
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam int TW = $clog2(RESP_TIMEOUT + 1);

  state_t        state_q, state_d;
  letter_t       cur_orig_q, cur_orig_d;
  letter_t       cur_code_q, cur_code_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          enc_valid_q, enc_valid_d;
  letter_t       enc_letter_q, enc_letter_d;
  letter_t       orig_q, orig_d;
  letter_t       code_q, code_d;
  logic          ovf_q, ovf_d;
  logic          tmo_pulse_q, tmo_pulse_d;

  logic    key_push, fifo_pop, fifo_full, fifo_empty;
  letter_t fifo_head;
  logic    unused_fc;

  assign key_push = key_valid_in & letter_ok(key_letter_in);
  assign fifo_pop = (state_q == ST_IDLE) & ~fifo_empty;

  enigma_key_fifo #(.DEPTH(FIFO_DEPTH)) u_key_fifo (
    .clk      (clk_pixel),
    .rst_n    (rst_n_in),
    .push_vld (key_push),
    .push_dat (key_letter_in),
    .pop_rdy  (fifo_pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    cur_orig_d   = cur_orig_q;
    cur_code_d   = cur_code_q;
    hold_d       = hold_q;
    tmo_d        = tmo_q;
    enc_valid_d  = enc_valid_q;
    enc_letter_d = enc_letter_q;
    orig_d       = orig_q;
    code_d       = code_q;
    tmo_pulse_d  = 1'b0;
    ovf_d        = ovf_q | (key_push & fifo_full & ~fifo_pop);
    case (state_q)
      ST_IDLE: if (!fifo_empty) begin
        cur_orig_d   = fifo_head;
        enc_valid_d  = 1'b1;
        enc_letter_d = fifo_head;
        state_d      = ST_ISSUE;
      end
      ST_ISSUE: if (enc_ready_in) begin
        enc_valid_d  = 1'b0;
        enc_letter_d = LETTER_NONE;
        tmo_d        = '0;
        state_d      = ST_WAIT_RESP;
      end
      // A response in the final timeout cycle still wins.
      ST_WAIT_RESP: if (enc_resp_valid_in) begin
        cur_code_d = enc_resp_letter_in;
        state_d    = ST_ARM;
      end else if (tmo_q == TW'(RESP_TIMEOUT - 1)) begin
        tmo_pulse_d = 1'b1;
        state_d     = ST_IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
      ST_ARM: if (nf_in) begin
        orig_d  = cur_orig_q;
        code_d  = cur_code_q;
        hold_d  = HW'(HOLD_FRAMES - 1);
        state_d = ST_SHOW;
      end
      // With more keys queued the lamps stay lit until the next pair loads, avoiding a blank frame.
      ST_SHOW: if (nf_in) begin
        if (hold_q == '0) begin
          if (fifo_empty) begin
            orig_d = LETTER_NONE;
            code_d = LETTER_NONE;
          end
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_IDLE;
      cur_orig_q   <= LETTER_NONE;
      cur_code_q   <= LETTER_NONE;
      hold_q       <= '0;
      tmo_q        <= '0;
      enc_valid_q  <= 1'b0;
      enc_letter_q <= LETTER_NONE;
      orig_q       <= LETTER_NONE;
      code_q       <= LETTER_NONE;
      ovf_q        <= 1'b0;
      tmo_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_orig_q   <= cur_orig_d;
      cur_code_q   <= cur_code_d;
      hold_q       <= hold_d;
      tmo_q        <= tmo_d;
      enc_valid_q  <= enc_valid_d;
      enc_letter_q <= enc_letter_d;
      orig_q       <= orig_d;
      code_q       <= code_d;
      ovf_q        <= ovf_d;
      tmo_pulse_q  <= tmo_pulse_d;
    end
  end

  assign enc_valid_out   = enc_valid_q;
  assign enc_letter_out  = enc_letter_q;
  assign orig_letter_out = orig_q;
  assign busy_out        = (state_q != ST_IDLE) | ~fifo_empty;
  assign overflow_out    = ovf_q;
  assign timeout_out     = tmo_pulse_q;
  assign unused_fc       = ^fc_in;

`ifdef ENIGMA_LAMP_BLINK_EN
  assign code_letter_out = ((state_q == ST_SHOW) && fc_in[3]) ? LETTER_NONE : code_q;
`else
  assign code_letter_out = code_q;
`endif

endmodule

// File: tb/tb_enigma_lamp_scheduler.sv
// Directed bench for enigma_lamp_scheduler: frame generator, cipher-core responder, per-frame lamp log.
module tb_enigma_lamp_scheduler;

  localparam int FRAME = 16;
  localparam logic [4:0] CODE_OFS = 5'd16;

  logic       clk_pixel = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       key_valid_in = 1'b0;
  logic [4:0] key_letter_in = '0;
  logic       nf_in = 1'b0;
  logic [5:0] fc_in = '0;
  logic       enc_valid_out;
  logic [4:0] enc_letter_out;
  logic       enc_ready_in = 1'b0;
  logic       enc_resp_valid_in = 1'b0;
  logic [4:0] enc_resp_letter_in = '0;
  logic [4:0] orig_letter_out, code_letter_out;
  logic       busy_out, overflow_out, timeout_out;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk_pixel = ~clk_pixel;

  enigma_lamp_scheduler dut (
    .clk_pixel          (clk_pixel),
    .rst_n_in           (rst_n_in),
    .key_valid_in       (key_valid_in),
    .key_letter_in      (key_letter_in),
    .nf_in              (nf_in),
    .fc_in              (fc_in),
    .enc_valid_out      (enc_valid_out),
    .enc_letter_out     (enc_letter_out),
    .enc_ready_in       (enc_ready_in),
    .enc_resp_valid_in  (enc_resp_valid_in),
    .enc_resp_letter_in (enc_resp_letter_in),
    .orig_letter_out    (orig_letter_out),
    .code_letter_out    (code_letter_out),
    .busy_out           (busy_out),
    .overflow_out       (overflow_out),
    .timeout_out        (timeout_out)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Frame generator; logs the lamp pair shown during each frame just before the next nf pulse.
  logic [9:0] frame_log[$];
  initial begin
    forever begin
      repeat (FRAME - 1) @(negedge clk_pixel);
      frame_log.push_back({orig_letter_out, code_letter_out});
      nf_in = 1'b1;
      fc_in = fc_in + 6'd1;
      @(negedge clk_pixel);
      nf_in = 1'b0;
    end
  end

  // Cipher core model: grants, then answers orig+16 a few cycles later.
  bit         core_stall = 1'b0;
  bit         core_respond = 1'b1;
  int         hs_cnt = 0;
  int         dly = -1;
  logic [4:0] pend = '0;
  initial begin
    forever begin
      @(negedge clk_pixel);
      enc_resp_valid_in = 1'b0;
      if (enc_ready_in) begin
        enc_ready_in = 1'b0;
        hs_cnt++;
        if (core_respond) dly = 1;
      end else if (dly > 0) begin
        dly--;
      end else if (dly == 0) begin
        enc_resp_valid_in  = 1'b1;
        enc_resp_letter_in = pend + CODE_OFS;
        dly = -1;
      end else if (!core_stall && enc_valid_out) begin
        enc_ready_in = 1'b1;
        pend = enc_letter_out;
      end
    end
  end

  task automatic push_key(input logic [4:0] l);
    @(negedge clk_pixel);
    key_valid_in  = 1'b1;
    key_letter_in = l;
    @(negedge clk_pixel);
    key_valid_in  = 1'b0;
    key_letter_in = '0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    @(negedge clk_pixel);
    while (busy_out && n < budget) begin
      @(negedge clk_pixel);
      n++;
    end
    chk_eq(tag, 32'(busy_out), 32'd0);
  endtask

  function automatic logic [9:0] pr(input int o, input int c);
    return {o[4:0], c[4:0]};
  endfunction

  // Collapse the frame log into runs of identical lit pairs and compare against the expected runs.
  task automatic analyze(input string tag, input logic [9:0] ev[$], input int el[$]);
    logic [9:0] rv[$];
    int rl[$];
    int gaps = 0;
    int zpend = 0;
    for (int i = 0; i < frame_log.size(); i++) begin
      if (frame_log[i] == 10'd0) begin
        if (rv.size() > 0) zpend++;
      end else begin
        gaps += zpend;
        if (rv.size() > 0 && zpend == 0 && rv[rv.size()-1] == frame_log[i]) begin
          rl[rl.size()-1]++;
        end else begin
          rv.push_back(frame_log[i]);
          rl.push_back(1);
        end
        zpend = 0;
      end
    end
    chk_eq({tag, "_runs"}, 32'(rv.size()), 32'(ev.size()));
    for (int i = 0; i < ev.size(); i++) begin
      chk_eq($sformatf("%s_pair%0d", tag, i), (i < rv.size()) ? 32'(rv[i]) : 32'hffff, 32'(ev[i]));
      chk_eq($sformatf("%s_len%0d", tag, i), (i < rl.size()) ? 32'(rl[i]) : 32'hffff, 32'(el[i]));
    end
    chk_eq({tag, "_gaps"}, 32'(gaps), 32'd0);
    chk_eq({tag, "_dark_end"}, (frame_log.size() > 0) ? 32'(frame_log[frame_log.size()-1]) : 32'hffff, 32'd0);
  endtask

  initial begin
    logic [9:0] ev[$];
    int el[$];
    int n, h0;

    // Reset state
    repeat (3) @(negedge clk_pixel);
    chk_eq("rst_enc_valid", 32'(enc_valid_out), 0);
    chk_eq("rst_enc_letter", 32'(enc_letter_out), 0);
    chk_eq("rst_orig", 32'(orig_letter_out), 0);
    chk_eq("rst_code", 32'(code_letter_out), 0);
    chk_eq("rst_busy", 32'(busy_out), 0);
    chk_eq("rst_ovf", 32'(overflow_out), 0);
    chk_eq("rst_tmo", 32'(timeout_out), 0);
    rst_n_in = 1'b1;

    // Invalid letter codes are dropped silently
    push_key(5'd0);
    push_key(5'd27);
    push_key(5'd31);
    repeat (3) @(negedge clk_pixel);
    chk_eq("inv_busy", 32'(busy_out), 0);
    chk_eq("inv_ovf", 32'(overflow_out), 0);
    chk_eq("inv_enc_valid", 32'(enc_valid_out), 0);

    // Single key A -> Q, shown for 30 frames then dark
    frame_log.delete();
    push_key(5'd1);
    wait_idle("single_idle", 40 * FRAME);
    chk_eq("single_req", 32'(pend), 1);
    repeat (2 * FRAME) @(negedge clk_pixel);
    ev = {}; el = {};
    ev.push_back(pr(1, 17)); el.push_back(30);
    analyze("single", ev, el);

    // Backpressure: request must hold steady while the core stalls
    core_stall = 1'b1;
    h0 = hs_cnt;
    frame_log.delete();
    push_key(5'd5);
    n = 0;
    while (!enc_valid_out && n < 20) begin
      @(negedge clk_pixel);
      n++;
    end
    chk_eq("bp_valid_up", 32'(enc_valid_out), 1);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_pixel);
      if (!(enc_valid_out && enc_letter_out == 5'd5)) n++;
    end
    chk_eq("bp_unstable_cycles", 32'(n), 0);
    core_stall = 1'b0;
    wait_idle("bp_idle", 40 * FRAME);
    chk_eq("bp_handshakes", 32'(hs_cnt - h0), 1);
    repeat (2 * FRAME) @(negedge clk_pixel);
    ev = {}; el = {};
    ev.push_back(pr(5, 21)); el.push_back(30);
    analyze("bp", ev, el);

    // Timeout: core grants but never answers
    core_respond = 1'b0;
    push_key(5'd9);
    n = 0;
    while (!enc_valid_out && n < 20) begin
      @(posedge clk_pixel); #1;
      n++;
    end
    n = 0;
    while (enc_valid_out && n < 20) begin
      @(posedge clk_pixel); #1;
      n++;
    end
    n = 0;
    while (!timeout_out && n < 2000) begin
      @(posedge clk_pixel); #1;
      n++;
    end
    chk_eq("tmo_cycle", 32'(n), 1024);
    @(posedge clk_pixel); #1;
    chk_eq("tmo_pulse_end", 32'(timeout_out), 0);
    chk_eq("tmo_busy", 32'(busy_out), 0);
    chk_eq("tmo_orig", 32'(orig_letter_out), 0);
    chk_eq("tmo_code", 32'(code_letter_out), 0);
    core_respond = 1'b1;

    // Overflow: six keys back-to-back against a stalled core
    core_stall = 1'b1;
    frame_log.delete();
    @(negedge clk_pixel);
    for (int k = 0; k < 6; k++) begin
      key_valid_in  = 1'b1;
      key_letter_in = 5'(2 + k);
      @(negedge clk_pixel);
    end
    key_valid_in  = 1'b0;
    key_letter_in = '0;
    @(negedge clk_pixel);
    chk_eq("ovf_flag", 32'(overflow_out), 1);
    chk_eq("ovf_busy", 32'(busy_out), 1);
    core_stall = 1'b0;
    wait_idle("ovf_idle", 200 * FRAME);
    repeat (2 * FRAME) @(negedge clk_pixel);
    ev = {}; el = {};
    for (int k = 0; k < 5; k++) begin
      ev.push_back(pr(2 + k, 18 + k));
      el.push_back((k < 4) ? 31 : 30);
    end
    analyze("ovf", ev, el);
    chk_eq("ovf_sticky", 32'(overflow_out), 1);

    // Asynchronous reset while a pair is lit
    push_key(5'd4);
    n = 0;
    while (orig_letter_out == 5'd0 && n < 40 * FRAME) begin
      @(negedge clk_pixel);
      n++;
    end
    chk_eq("rshow_lit", 32'(orig_letter_out), 4);
    @(negedge clk_pixel);
    #2 rst_n_in = 1'b0;
    #1;
    chk_eq("rshow_orig", 32'(orig_letter_out), 0);
    chk_eq("rshow_code", 32'(code_letter_out), 0);
    chk_eq("rshow_busy", 32'(busy_out), 0);
    chk_eq("rshow_ovf", 32'(overflow_out), 0);
    chk_eq("rshow_enc_valid", 32'(enc_valid_out), 0);
    @(negedge clk_pixel);
    rst_n_in = 1'b1;
    repeat (4) @(negedge clk_pixel);
    chk_eq("rshow_after_busy", 32'(busy_out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
